// File: rtl/unsign_addsub_serial.sv
// unsign_addsub_serial
//   Bit-serial unsigned adder/subtractor. A single full-adder slice works
//   through the operands LSB first, one bit per clock. A transaction takes
//   INPUT_BIT_WIDTH cycles to compute. Operands and results move through
//   valid/ready handshakes. The result is the same as the combinational
//   UnsignAddSub, so this block can also serve as a cross-check for it.
//
// Ports
//   Clk        in   rising-edge clock
//   RstN       in   asynchronous active-low reset
//   InValid    in   operand transaction offered
//   InReady    out  operands accepted this cycle (IDLE only)
//   InputA     in   operand A, unsigned
//   InputB     in   operand B, unsigned
//   AddSubMode in   0 = A+B, 1 = A-B
//   OutValid   out  Result/CarryFlag valid (DONE only)
//   OutReady   in   downstream accepts result
//   Result     out  (A op B) mod 2^INPUT_BIT_WIDTH
//   CarryFlag  out  add: carry-out; sub: borrow (1 when A<B)
//   Busy       out  high in RUN and DONE
module unsign_addsub_serial #(
  parameter int INPUT_BIT_WIDTH = 8
) (
  input  logic                       Clk,
  input  logic                       RstN,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [INPUT_BIT_WIDTH-1:0] InputA,
  input  logic [INPUT_BIT_WIDTH-1:0] InputB,
  input  logic                       AddSubMode,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [INPUT_BIT_WIDTH-1:0] Result,
  output logic                       CarryFlag,
  output logic                       Busy
);

  localparam int W  = INPUT_BIT_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT          stateReg, stateNext;
  logic [1:0]     rstSyncReg;
  logic [CW-1:0]  cntReg;
  logic [W-1:0]   aReg;
  logic [W-1:0]   bReg;
  logic           modeReg;
  logic           carryReg;
  logic [W-1:0]   resultReg;
  logic           carryFlagReg;

  logic           accept;
  logic           lastBit;
  logic           bEff;
  logic           sumBit;
  logic           carryNext;

  // Reset assertion is asynchronous. Reset release is synchronised before
  // the FSM may leave IDLE. This keeps the first acceptance clear of the
  // recovery window.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      rstSyncReg <= 2'b00;
    end else begin
      rstSyncReg <= {rstSyncReg[0], 1'b1};
    end
  end

  // Single full-adder slice. Subtraction is A + ~B + 1: B is inverted here,
  // and the +1 comes from presetting the carry to the mode bit.
  always_comb begin
    bEff      = bReg[0] ^ modeReg;
    sumBit    = aReg[0] ^ bEff ^ carryReg;
    carryNext = (aReg[0] & bEff) | (aReg[0] & carryReg) | (bEff & carryReg);
    lastBit   = (cntReg == LastCnt);
  end

  // FSM: state register
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // FSM: next state and handshake outputs
  always_comb begin
    stateNext = stateReg;
    InReady   = 1'b0;
    OutValid  = 1'b0;
    Busy      = 1'b0;
    accept    = 1'b0;
    case (stateReg)
      IDLE: begin
        InReady = 1'b1;
        accept  = InValid & rstSyncReg[1];
        if (accept) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        Busy = 1'b1;
        if (lastBit) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        Busy     = 1'b1;
        OutValid = 1'b1;
        if (OutReady) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Datapath. Sum bits are shifted into the MSB of the A register as A
  // shifts out. After W steps the A register holds the complete sum. The
  // sum is copied to the visible result register on the final step. This
  // keeps Result/CarryFlag stable through RUN and IDLE.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      cntReg       <= '0;
      aReg         <= '0;
      bReg         <= '0;
      modeReg      <= 1'b0;
      carryReg     <= 1'b0;
      resultReg    <= '0;
      carryFlagReg <= 1'b0;
    end else begin
      if (accept) begin
        aReg     <= InputA;
        bReg     <= InputB;
        modeReg  <= AddSubMode;
        carryReg <= AddSubMode;
        cntReg   <= '0;
      end else if (stateReg == RUN) begin
        aReg     <= {sumBit, aReg[W-1:1]};
        bReg     <= {1'b0, bReg[W-1:1]};
        carryReg <= carryNext;
        if (lastBit) begin
          // Wrap to zero instead of counting past W-1.
          cntReg       <= '0;
          resultReg    <= {sumBit, aReg[W-1:1]};
          // On subtraction the carry-out is the inverse of the borrow.
          carryFlagReg <= modeReg ? ~carryNext : carryNext;
        end else begin
          cntReg <= cntReg + 1'b1;
        end
      end
    end
  end

  assign Result    = resultReg;
  assign CarryFlag = carryFlagReg;

endmodule

// File: tb/tb_unsign_addsub_serial.sv
module tb_unsign_addsub_serial;

  localparam int W = 8;

  logic         Clk;
  logic         RstN;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] InputA;
  logic [W-1:0] InputB;
  logic         AddSubMode;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] Result;
  logic         CarryFlag;
  logic         Busy;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  unsign_addsub_serial #(.INPUT_BIT_WIDTH(W)) dut (
    .Clk       (Clk),
    .RstN      (RstN),
    .InValid   (InValid),
    .InReady   (InReady),
    .InputA    (InputA),
    .InputB    (InputB),
    .AddSubMode(AddSubMode),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .Result    (Result),
    .CarryFlag (CarryFlag),
    .Busy      (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full transaction: offer, check latency and result, then take it.
  task automatic runTxn(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input logic [W-1:0] expR, input logic expC, input string tag);
    int n;
    @(negedge Clk);
    InputA = a; InputB = b; AddSubMode = m; InValid = 1'b1;
    check({tag, "_inready"}, InReady, 1);
    @(posedge Clk); #1;
    InValid = 1'b0;
    // Captured operands must not follow the inputs.
    InputA = ~a; InputB = ~b; AddSubMode = ~m;
    check({tag, "_busy"}, Busy, 1);
    n = 0;
    while (!OutValid && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, W);
    check({tag, "_result"}, Result, expR);
    check({tag, "_carry"}, CarryFlag, expC);
    @(negedge Clk);
    OutReady = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b0;
    check({tag, "_ovdrop"}, OutValid, 0);
    check({tag, "_idle_ready"}, InReady, 1);
    check({tag, "_hold"}, Result, expR);
    $display("txn %s: A=%0d B=%0d mode=%0d -> Result=%0d Carry=%0d", tag, a, b, m, Result, CarryFlag);
  endtask

  logic [W:0]   expQ[$];
  logic [W:0]   expV;
  logic [W-1:0] curA, curB;
  logic         curM;
  logic         accepted;
  int           n, cyc, lastSeen, got;

  initial begin
    RstN = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    InputA = '0; InputB = '0; AddSubMode = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_inready", InReady, 1);
    check("rst_outvalid", OutValid, 0);
    check("rst_result", Result, 0);
    check("rst_carry", CarryFlag, 0);
    check("rst_busy", Busy, 0);
    RstN = 1'b1;
    repeat (3) @(negedge Clk);

    // Directed vectors
    runTxn(8'd20,  8'd8,   1'b0, 8'd28,  1'b0, "add_20_8");
    runTxn(8'd20,  8'd8,   1'b1, 8'd12,  1'b0, "sub_20_8");
    runTxn(8'd8,   8'd20,  1'b1, 8'd244, 1'b1, "sub_8_20");
    runTxn(8'd200, 8'd100, 1'b0, 8'd44,  1'b1, "add_200_100");
    runTxn(8'd255, 8'd255, 1'b1, 8'd0,   1'b0, "sub_255_255");
    runTxn(8'd0,   8'd1,   1'b1, 8'd255, 1'b1, "sub_0_1");

    // Stall in DONE: 100-50 = 50. A fresh offer is present, but it must be
    // ignored until the result is taken.
    @(negedge Clk);
    InputA = 8'd100; InputB = 8'd50; AddSubMode = 1'b1; InValid = 1'b1;
    @(posedge Clk); #1;
    InputA = 8'd3; InputB = 8'd4; AddSubMode = 1'b0;
    n = 0;
    while (!OutValid && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    check("stall_latency", n, W);
    for (int i = 0; i < 5; i++) begin
      check("stall_outvalid", OutValid, 1);
      check("stall_result", Result, 50);
      check("stall_carry", CarryFlag, 0);
      check("stall_inready", InReady, 0);
      @(posedge Clk); #1;
    end
    $display("txn stall: A=100 B=50 mode=1 held 5 cycles -> Result=%0d Carry=%0d", Result, CarryFlag);
    OutReady = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b0;
    check("stall_taken_inready", InReady, 1);
    check("stall_taken_result", Result, 50);
    @(posedge Clk); #1;
    InValid = 1'b0;
    check("pending_accepted_busy", Busy, 1);
    n = 0;
    while (!OutValid && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    check("pending_latency", n, W);
    check("pending_result", Result, 7);
    check("pending_carry", CarryFlag, 0);
    $display("txn pending: A=3 B=4 mode=0 -> Result=%0d Carry=%0d", Result, CarryFlag);
    OutReady = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b0;

    // Back-to-back with both handshakes tied high
    curA = W'($urandom); curB = W'($urandom); curM = 1'($urandom);
    InputA = curA; InputB = curB; AddSubMode = curM;
    InValid = 1'b1; OutReady = 1'b1;
    cyc = 0; lastSeen = -1; got = 0;
    while (got < 100 && cyc < 2000) begin
      @(negedge Clk);
      cyc++;
      if (OutValid) begin
        if (expQ.size() > 0) begin
          expV = expQ.pop_front();
          check("b2b_result", Result, expV[W-1:0]);
          check("b2b_carry", CarryFlag, expV[W]);
          $display("txn b2b %0d: Result=%0d Carry=%0d expected %0d/%0d", got, Result, CarryFlag, expV[W-1:0], expV[W]);
        end else begin
          check("b2b_unexpected_result", 1, 0);
        end
        if (lastSeen >= 0) check("b2b_spacing", cyc - lastSeen, W + 2);
        lastSeen = cyc;
        got++;
      end
      accepted = InReady;
      if (InReady) begin
        expQ.push_back(curM ? ({1'b0, curA} - {1'b0, curB}) : ({1'b0, curA} + {1'b0, curB}));
      end
      @(posedge Clk); #1;
      if (accepted) begin
        curA = W'($urandom); curB = W'($urandom); curM = 1'($urandom);
        InputA = curA; InputB = curB; AddSubMode = curM;
      end
    end
    check("b2b_count", got, 100);
    InValid = 1'b0;
    repeat (12) @(posedge Clk);
    #1;
    OutReady = 1'b0;
    check("b2b_drained", Busy, 0);

    // Reset in the middle of RUN
    @(negedge Clk);
    InputA = 8'd77; InputB = 8'd11; AddSubMode = 1'b0; InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    RstN = 1'b0;
    #1;
    check("midrst_inready", InReady, 1);
    check("midrst_outvalid", OutValid, 0);
    check("midrst_busy", Busy, 0);
    check("midrst_result", Result, 0);
    check("midrst_carry", CarryFlag, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    RstN = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("postrst_no_outvalid", OutValid, 0);
      check("postrst_inready", InReady, 1);
      @(negedge Clk);
    end
    $display("txn reset: aborted A=77 B=11 mid-RUN, outputs at reset values");
    runTxn(8'd77, 8'd11, 1'b0, 8'd88, 1'b0, "after_reset");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
